load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-memory access stage of the multi-cycle ARM core: it runs in the `dataMemory` state, between `execute` and `writeback`. It takes the decoded single-data-transfer fields and the register and ALU operands, computes the effective address, and performs one word or byte load or store over a request/ready memory port. It returns the load result and the base-register writeback value to the `writeback` state, with a one-cycle `done` pulse.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum `mem_req` cycles without `mem_ready` before the access is aborted with a fault.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- nreset  in  1  reset; asynchronous, active-low.
- start  in  1  begin access; sampled only in IDLE.
- load_store  in  1  1 = LDR, 0 = STR.
- byte_or_word  in  1  1 = byte, 0 = word.
- pre_post  in  1  1 = pre-index, 0 = post-index.
- up_down  in  1  1 = add offset, 0 = subtract offset.
- write_back  in  1  W bit.
- base_data  in  32  Rn value.
- offset_data  in  32  offset (immediate or shifted Rm).
- store_data  in  32  Rd value for STR.
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  store data.
- mem_wstrb  out  4  byte lane enables.
- mem_req  out  1  access request.
- mem_we  out  1  write request.
- mem_ready  in  1  access complete, same cycle as `mem_req`.
- mem_rdata  in  32  read data, valid with `mem_ready`.
- load_data  out  32  registered LDR result.
- rd_wr_en  out  1  write `load_data` to Rd; asserted with `done`.
- base_wb_data  out  32  new Rn value.
- base_wb_en  out  1  write Rn; asserted with `done`.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high in any state other than IDLE.
- fault  out  1  misalignment or timeout; asserted with `done`.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - `start` = 1 latches all operands and computes `eff = up_down ? base+offset : base-offset`, modulo 2^32, with carry discarded.
  - `addr = pre_post ? eff : base_data`.
  - Word access with `addr[1:0] != 0`: go to RESP with `fault` = 1. No memory request is issued and no register writes occur.
  - Otherwise go to ACCESS.
- ACCESS:
  - `mem_req` = 1 and `mem_we = ~load_store`.
  - Word access: `mem_wstrb = 4'b1111`, `mem_wdata = store_data`.
  - Byte access: `mem_wstrb = 1 << addr[1:0]`, `mem_wdata = {4{store_data[7:0]}}`.
  - On `mem_ready` = 1, capture `load_data`:
    - word: `mem_rdata`;
    - byte: lane `addr[1:0]`, zero-extended.
  - Then go to RESP.
  - The wait counter increments each ACCESS cycle without ready. When it reaches TIMEOUT_CYCLES, drop `mem_req`, go to RESP with `fault` = 1 and suppress all writes.
- RESP:
  - `done` = 1 for one cycle.
  - `rd_wr_en = load_store & ~fault`.
  - `base_wb_en = (write_back | ~pre_post) & ~fault`; post-index always writes back.
  - `base_wb_data = eff`.
  - Next state is IDLE.
- `start` outside IDLE is ignored.
- `mem_addr`, `mem_wdata`, `mem_wstrb` and `mem_we` are held stable for the whole of ACCESS.
- Reset values: state IDLE; counter 0; every output 0.

## Timing
- Zero-wait-state access: `start` at cycle 0, `mem_req` at cycle 1 with ready at cycle 1, `done` at cycle 2. Latency is 2 cycles.
- With N wait cycles, `done` is at cycle 2+N.
- Misaligned access: `done` plus `fault` at cycle 1, with no `mem_req` ever asserted.
- Timeout: `mem_req` is high for exactly TIMEOUT_CYCLES cycles, then `done` plus `fault` on the next cycle.
- `mem_ready` while `mem_req` = 0 is ignored.
- Reset asserted mid-access clears state and outputs immediately, without waiting for a clock edge, and `mem_req` drops asynchronously. After release, the unit idles until the next `start`.
- `start` asserted in the same cycle as `done` is ignored; the unit accepts `start` from the cycle after `done`.

## Structure
- A shared `cpu_pkg` holds:
  - state encodings: IDLE = 2'b00, ACCESS = 2'b01, RESP = 2'b10;
  - the SDT field-bit constants shared with the instruction decoder.
- One sub-module, `byte_lane_align`: combinational lane selection for loads and lane/strobe replication for stores, instantiated once.

## Test plan
- LDR word, pre-index, up: base 0x100, offset 0x8, W = 1, rdata 0xDEADBEEF, ready immediately -> `mem_addr` 0x108; `done` at cycle 2; `load_data` 0xDEADBEEF; Rn 0x108 with `base_wb_en` = 1.
- STRB, post-index, down: base 0x203, offset 4, store 0x12345678 -> `mem_addr` 0x203, `wstrb` 4'b1000, `wdata` 0x78787878; Rn = 0x1FF written back; `rd_wr_en` = 0.
- LDRB lane 2: address 0x402, rdata 0xAABBCCDD, 3 wait cycles -> `load_data` 0x000000BB; `done` at cycle 5.
- Misaligned LDR at 0x101 -> `fault` plus `done` at cycle 1; `mem_req` never asserted; no register writes.
- TIMEOUT_CYCLES = 4 with ready held low -> `mem_req` high for 4 cycles, then `fault` plus `done`; no writes.
- `nreset` asserted during a wait cycle -> `mem_req`, `busy` and all outputs 0 immediately; after release, a new zero-wait-state LDR completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: load/store FSM encodings,
// single-data-transfer field positions and small address helpers.
package cpu_pkg;

   // Load/store unit states; encodings are fixed because other core
   // logic and debug views decode them directly.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } lsu_state_t;

   // Single-data-transfer instruction bit positions, shared with the decoder.
   localparam int SDT_BIT_I = 25;  // register (shifted) offset
   localparam int SDT_BIT_P = 24;  // pre/post index
   localparam int SDT_BIT_U = 23;  // up/down
   localparam int SDT_BIT_B = 22;  // byte/word
   localparam int SDT_BIT_W = 21;  // write-back
   localparam int SDT_BIT_L = 20;  // load/store

   // Operands captured when an access is accepted.
   typedef struct packed {
      logic        load_store;
      logic        byte_or_word;
      logic        pre_post;
      logic        write_back;
      logic [31:0] eff;
      logic [31:0] addr;
      logic [31:0] store_data;
   } sdt_req_t;

   // Effective address, modulo 2^32 (carry/borrow discarded).
   function automatic logic [31:0] sdt_eff_addr(input logic [31:0] base,
                                                input logic [31:0] offset,
                                                input logic        up);
      return up ? (base + offset) : (base - offset);
   endfunction

   // Word accesses must be 4-byte aligned; byte accesses never fault.
   function automatic logic sdt_misaligned(input logic [1:0] addr_lo,
                                           input logic       is_byte);
      return !is_byte && (addr_lo != 2'b00);
   endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Byte-lane steering between the 32-bit memory port and the register file:
// lane extraction for loads, data replication and strobes for stores.
module byte_lane_align (
   input  logic        byte_or_word,
   input  logic [1:0]  lane,
   input  logic [31:0] store_data,
   input  logic [31:0] mem_rdata,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic [31:0] rdata_aligned
);

   // Select write lanes and load lane from the access size and address.
   always_comb begin
      if (byte_or_word) begin
         wstrb         = 4'b0001 << lane;
         wdata         = {4{store_data[7:0]}};
         rdata_aligned = {24'h000000, mem_rdata[{lane, 3'b000} +: 8]};
      end else begin
         wstrb         = 4'b1111;
         wdata         = store_data;
         rdata_aligned = mem_rdata;
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: computes the effective address, performs one word or
// byte access over a req/ready port and returns load and base write-back
// results with a single-cycle done pulse.
module load_store_unit
   import cpu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        start,
   input  logic        load_store,
   input  logic        byte_or_word,
   input  logic        pre_post,
   input  logic        up_down,
   input  logic        write_back,
   input  logic [31:0] base_data,
   input  logic [31:0] offset_data,
   input  logic [31:0] store_data,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   output logic        mem_req,
   output logic        mem_we,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [31:0] load_data,
   output logic        rd_wr_en,
   output logic [31:0] base_wb_data,
   output logic        base_wb_en,
   output logic        done,
   output logic        busy,
   output logic        fault
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   lsu_state_t        state, state_next;
   sdt_req_t          req_in, req_q;
   logic [CNT_W-1:0]  wait_cnt;
   logic              fault_q;
   logic [31:0]       load_q;
   logic              misaligned_in;
   logic              timeout_hit;
   logic [31:0]       lane_wdata;
   logic [3:0]        lane_wstrb;
   logic [31:0]       lane_rdata;

   // Operands as they will be captured on an accepted start.
   assign req_in.load_store   = load_store;
   assign req_in.byte_or_word = byte_or_word;
   assign req_in.pre_post     = pre_post;
   assign req_in.write_back   = write_back;
   assign req_in.eff          = sdt_eff_addr(base_data, offset_data, up_down);
   assign req_in.addr         = pre_post ? req_in.eff : base_data;
   assign req_in.store_data   = store_data;

   assign misaligned_in = sdt_misaligned(req_in.addr[1:0], byte_or_word);

   // Last permitted un-acknowledged request cycle: abort instead of waiting.
   assign timeout_hit = (state == ST_ACCESS) && !mem_ready &&
                        (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   byte_lane_align u_lane (
      .byte_or_word  (req_q.byte_or_word),
      .lane          (req_q.addr[1:0]),
      .store_data    (req_q.store_data),
      .mem_rdata     (mem_rdata),
      .wdata         (lane_wdata),
      .wstrb         (lane_wstrb),
      .rdata_aligned (lane_rdata)
   );

   // State register.
   always_ff @(posedge clk or negedge nreset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      if (!nreset) state <= ST_IDLE;
      else         state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default first so no path through the case infers a latch.
      state_next = state;
      case (state)
         ST_IDLE:   if (start) state_next = misaligned_in ? ST_RESP : ST_ACCESS;
         ST_ACCESS: if (mem_ready || timeout_hit) state_next = ST_RESP;
         ST_RESP:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // Operand capture, wait counting, load capture and fault tracking.
   always_ff @(posedge clk or negedge nreset) begin
      // NOTE: the captured operands are reset as well, so every output,
      // including load_data, reads 0 straight out of reset.
      if (!nreset) begin
         req_q    <= '0;
         fault_q  <= 1'b0;
         wait_cnt <= '0;
         load_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  req_q    <= req_in;
                  fault_q  <= misaligned_in;
                  wait_cnt <= '0;
               end
            end
            ST_ACCESS: begin
               if (mem_ready) begin
                  if (req_q.load_store) load_q <= lane_rdata;
               end else if (timeout_hit) begin
                  fault_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from state; memory-side outputs only during ACCESS.
   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_wstrb    = '0;
      done         = 1'b0;
      fault        = 1'b0;
      rd_wr_en     = 1'b0;
      base_wb_en   = 1'b0;
      base_wb_data = '0;
      busy         = (state != ST_IDLE);
      case (state)
         ST_ACCESS: begin
            mem_req   = 1'b1;
            mem_we    = ~req_q.load_store;
            mem_addr  = req_q.addr;
            mem_wdata = lane_wdata;
            mem_wstrb = lane_wstrb;
         end
         ST_RESP: begin
            done         = 1'b1;
            fault        = fault_q;
            rd_wr_en     = req_q.load_store & ~fault_q;
            base_wb_en   = (req_q.write_back | ~req_q.pre_post) & ~fault_q;
            base_wb_data = req_q.eff;
         end
         default: ;
      endcase
   end

   assign load_data = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver queues expected results
// and memory-side transactions; a monitor checks each done pulse and a
// memory responder checks the request signals and supplies ready/data.
module tb_load_store_unit;

   typedef struct {
      logic [31:0] ld_data;
      logic        chk_load;
      logic        rd_en;
      logic [31:0] wb_data;
      logic        wb_en;
      logic        flt;
      int          lat;
      int          req;
      int          start_cyc;
   } exp_t;

   typedef struct {
      int          waits;
      logic [31:0] rdata;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        we;
   } mem_t;

   logic        clk = 1'b0;
   logic        nreset;
   logic        start, load_store, byte_or_word, pre_post, up_down, write_back;
   logic [31:0] base_data, offset_data, store_data;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] load_data, base_wb_data;
   logic        rd_wr_en, base_wb_en, done, busy, fault;

   exp_t exp_q[$];
   mem_t mem_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   done_cnt = 0;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk          (clk),
      .nreset       (nreset),
      .start        (start),
      .load_store   (load_store),
      .byte_or_word (byte_or_word),
      .pre_post     (pre_post),
      .up_down      (up_down),
      .write_back   (write_back),
      .base_data    (base_data),
      .offset_data  (offset_data),
      .store_data   (store_data),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_wstrb    (mem_wstrb),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata),
      .load_data    (load_data),
      .rd_wr_en     (rd_wr_en),
      .base_wb_data (base_wb_data),
      .base_wb_en   (base_wb_en),
      .done         (done),
      .busy         (busy),
      .fault        (fault)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk_exp(input logic [31:0] ld, input logic chk_ld, input logic rd,
                                   input logic [31:0] wbd, input logic wbe, input logic flt,
                                   input int lat, input int req);
      exp_t e;
      e.ld_data = ld;  e.chk_load = chk_ld; e.rd_en = rd;
      e.wb_data = wbd; e.wb_en = wbe;       e.flt = flt;
      e.lat = lat;     e.req = req;         e.start_cyc = 0;
      return e;
   endfunction

   function automatic mem_t mk_mem(input int waits, input logic [31:0] rdata,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [3:0] wstrb, input logic we);
      mem_t m;
      m.waits = waits; m.rdata = rdata; m.addr = addr;
      m.wdata = wdata; m.wstrb = wstrb; m.we = we;
      return m;
   endfunction

   // Monitor: checks every done pulse against the scoreboard.
   initial begin : monitor
      int   req_cnt;
      exp_t e;
      req_cnt = 0;
      forever begin
         @(negedge clk);
         if (!nreset) begin
            req_cnt = 0;
         end else begin
            if (mem_req) req_cnt++;
            if (done) begin
               done_cnt++;
               if (exp_q.size() == 0) begin
                  check("spurious_done", 32'(done), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  if (e.chk_load) check("load_data", load_data, e.ld_data);
                  check("rd_wr_en",     32'(rd_wr_en),   32'(e.rd_en));
                  check("base_wb_en",   32'(base_wb_en), 32'(e.wb_en));
                  check("base_wb_data", base_wb_data,    e.wb_data);
                  check("fault",        32'(fault),      32'(e.flt));
                  check("latency",      32'(cyc - e.start_cyc), 32'(e.lat));
                  check("req_cycles",   32'(req_cnt),    32'(e.req));
               end
               req_cnt = 0;
            end
         end
      end
   end

   // Memory responder: checks request fields each cycle, answers after the
   // planned wait count, and holds ready high with junk data while idle.
   initial begin : responder
      mem_t cur;
      bit   active;
      int   wcnt;
      active    = 0;
      wcnt      = 0;
      cur       = mk_mem(0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
      mem_ready = 1'b1;
      mem_rdata = 32'hBAD0BAD0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            if (!active) begin
               active = 1;
               wcnt   = 0;
               if (mem_q.size() == 0) check("spurious_req", 32'(mem_req), 32'd0);
               else                   cur = mem_q.pop_front();
            end
            check("mem_addr",  mem_addr,          cur.addr);
            check("mem_we",    32'(mem_we),       32'(cur.we));
            check("mem_wstrb", 32'(mem_wstrb),    32'(cur.wstrb));
            check("mem_wdata", mem_wdata,         cur.wdata);
            if (wcnt == cur.waits) begin
               mem_ready = 1'b1;
               mem_rdata = cur.rdata;
            end else begin
               mem_ready = 1'b0;
               mem_rdata = 32'h5A5A0000 + 32'(wcnt);
            end
            wcnt++;
         end else begin
            active    = 0;
            mem_ready = 1'b1;
            mem_rdata = 32'hBAD0BAD0;
         end
      end
   end

   task automatic issue(input logic ls, input logic bw, input logic pp, input logic ud,
                        input logic wb, input logic [31:0] base, input logic [31:0] off,
                        input logic [31:0] sd, input int hold, input bit expect_done,
                        input exp_t e, input bit has_mem, input mem_t m);
      exp_t ee;
      int   d0;
      @(negedge clk);
      ee = e;
      ee.start_cyc = cyc;
      d0 = done_cnt;
      if (expect_done) exp_q.push_back(ee);
      if (has_mem) mem_q.push_back(m);
      load_store = ls; byte_or_word = bw; pre_post = pp; up_down = ud; write_back = wb;
      base_data = base; offset_data = off; store_data = sd;
      start = 1'b1;
      repeat (hold) @(negedge clk);
      start = 1'b0;
      if (expect_done) begin
         for (int i = 0; i < 40 && done_cnt == d0; i++) @(negedge clk);
         check("done_seen", 32'(done_cnt - d0), 32'd1);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_req"},      32'(mem_req),    32'd0);
      check({tag, "_busy"},         32'(busy),       32'd0);
      check({tag, "_done"},         32'(done),       32'd0);
      check({tag, "_fault"},        32'(fault),      32'd0);
      check({tag, "_mem_we"},       32'(mem_we),     32'd0);
      check({tag, "_mem_addr"},     mem_addr,        32'd0);
      check({tag, "_mem_wdata"},    mem_wdata,       32'd0);
      check({tag, "_mem_wstrb"},    32'(mem_wstrb),  32'd0);
      check({tag, "_load_data"},    load_data,       32'd0);
      check({tag, "_rd_wr_en"},     32'(rd_wr_en),   32'd0);
      check({tag, "_base_wb_en"},   32'(base_wb_en), 32'd0);
      check({tag, "_base_wb_data"}, base_wb_data,    32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   mem_t no_mem;

   initial begin : driver
      no_mem = mk_mem(0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
      nreset = 1'b0;
      start = 1'b0; load_store = 1'b0; byte_or_word = 1'b0; pre_post = 1'b0;
      up_down = 1'b0; write_back = 1'b0;
      base_data = '0; offset_data = '0; store_data = '0;
      #1;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      nreset = 1'b1;
      repeat (2) @(negedge clk);

      // LDR word, pre-index up, W=1, zero wait
      issue(1, 0, 1, 1, 1, 32'h100, 32'h8, 32'h11111111, 1, 1,
            mk_exp(32'hDEADBEEF, 1, 1, 32'h108, 1, 0, 2, 1), 1,
            mk_mem(0, 32'hDEADBEEF, 32'h108, 32'h11111111, 4'b1111, 1'b0));

      // STRB post-index down: base written back even with W=0
      issue(0, 1, 0, 0, 0, 32'h203, 32'h4, 32'h12345678, 1, 1,
            mk_exp(32'h0, 0, 0, 32'h1FF, 1, 0, 2, 1), 1,
            mk_mem(0, 32'h0, 32'h203, 32'h78787878, 4'b1000, 1'b1));

      // LDRB lane 2, three wait cycles, pre-index W=0: no base write
      issue(1, 1, 1, 1, 0, 32'h400, 32'h2, 32'h000000A5, 1, 1,
            mk_exp(32'h000000BB, 1, 1, 32'h402, 0, 0, 5, 4), 1,
            mk_mem(3, 32'hAABBCCDD, 32'h402, 32'hA5A5A5A5, 4'b0100, 1'b0));

      // Misaligned LDR word at 0x101 (post-index): fault, no request, no writes
      issue(1, 0, 0, 1, 1, 32'h101, 32'h4, 32'h0, 1, 1,
            mk_exp(32'h0, 0, 0, 32'h105, 0, 1, 1, 0), 0, no_mem);

      // Timeout: ready never comes within 4 request cycles
      issue(1, 0, 1, 1, 1, 32'h500, 32'h10, 32'h0, 1, 1,
            mk_exp(32'h0, 0, 0, 32'h510, 0, 1, 5, 4), 1,
            mk_mem(100, 32'h0, 32'h510, 32'h0, 4'b1111, 1'b0));

      // STR word with start held through done: only one access must happen
      issue(0, 0, 1, 1, 1, 32'h800, 32'h4, 32'hA1B2C3D4, 5, 1,
            mk_exp(32'h0, 0, 0, 32'h804, 1, 0, 4, 3), 1,
            mk_mem(2, 32'h0, 32'h804, 32'hA1B2C3D4, 4'b1111, 1'b1));
      repeat (3) @(negedge clk);

      // Asynchronous reset in the middle of a wait cycle
      issue(1, 0, 1, 1, 1, 32'h600, 32'h0, 32'h0, 1, 0,
            mk_exp(32'h0, 0, 0, 32'h0, 0, 0, 0, 0), 1,
            mk_mem(100, 32'h0, 32'h600, 32'h0, 4'b1111, 1'b0));
      repeat (2) @(negedge clk);
      check("pre_reset_req", 32'(mem_req), 32'd1);
      #2;
      nreset = 1'b0;
      #1;
      check_all_zero("async_reset");
      repeat (2) @(negedge clk);
      nreset = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_after_reset_busy", 32'(busy), 32'd0);

      // Zero-wait LDR after reset, pre-index down
      issue(1, 0, 1, 0, 1, 32'h700, 32'h10, 32'h0, 1, 1,
            mk_exp(32'hCAFEF00D, 1, 1, 32'h6F0, 1, 0, 2, 1), 1,
            mk_mem(0, 32'hCAFEF00D, 32'h6F0, 32'h0, 4'b1111, 1'b0));

      repeat (5) @(negedge clk);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check("mem_q_drained", 32'(mem_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
